lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised synchronous LIFO stack. It is the configurable-width, configurable-depth successor to the fixed 32-bit stack, and it sits on the datapath side of the processor for call/return and operand storage. Compared with the fixed stack it adds:
- full/empty status and an occupancy count;
- sticky overflow and underflow error flags;
- simultaneous push+pop, which replaces the top entry;
- a synchronous flush;
- a top-of-stack peek output.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each stack entry.
- DEPTH, 16, number of entries; legal values are DEPTH >= 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of count. This is derived and must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- write_en  input  1  push data_in this cycle.
- read_en  input  1  pop the top entry this cycle.
- data_in  input  DATA_WIDTH  push data.
- flush  input  1  synchronous empty of the stack.
- err_clr  input  1  clears the sticky error flags.
- data_out  output  DATA_WIDTH  registered value returned by the last accepted pop.
- rd_valid  output  1  one-cycle pulse; data_out was updated on this edge.
- top  output  DATA_WIDTH  current top entry (peek); 0 when empty.
- count  output  CNT_WIDTH  number of valid entries, range 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a push was rejected because the stack was full.
- underflow  output  1  sticky; a pop was rejected because the stack was empty.

## Operation
Storage and status:
- Storage is a DEPTH x DATA_WIDTH register array plus a stack pointer; the stack pointer equals count.
- The array is not reset. All control and output registers are reset.
- empty and full are decoded from count. top = mem[count-1] when count != 0, else 0.

Per-edge priority when rst_n is high:
1. flush: count <= 0 and rd_valid <= 0. data_out and the error flags hold. read_en and write_en are ignored that cycle.
2. write_en=1, read_en=1, not empty: replace.
   - data_out <= old top and rd_valid <= 1.
   - mem[count-1] <= data_in.
   - count unchanged. This is legal when full and raises no overflow.
3. write_en=1, read_en=1, empty: the push is performed (count becomes 1), the pop is rejected, underflow <= 1, rd_valid <= 0.
4. write_en only:
   - Not full: mem[count] <= data_in, count+1.
   - Full: entry dropped, contents unchanged, overflow <= 1.
5. read_en only:
   - Not empty: data_out <= mem[count-1], rd_valid <= 1, count-1.
   - Empty: underflow <= 1, data_out holds, rd_valid <= 0.
6. Idle: rd_valid <= 0; everything else holds.

Error flags:
- err_clr clears overflow and underflow.
- If a new error occurs in the same cycle as err_clr, the set wins.

Reset mid-operation:
- Asserting rst_n low at any time immediately forces: count=0, empty=1, full=0, data_out=0, rd_valid=0, overflow=0, underflow=0, top=0.
- Any in-progress push or pop is discarded.

## Timing
- Push latency: data written at edge k appears on top and is reflected in count/full/empty after edge k, i.e. in cycle k+1.
- Pop latency: data_out and rd_valid are valid in the cycle after the accepting edge. rd_valid is high for exactly one cycle per accepted pop, and back-to-back pops keep it high.
- full, empty and top are combinational from registered state. They carry no input-to-output combinational path.
- Status is always current, so the producer checks full and the consumer checks empty before asserting. A rejected request has no effect other than its error flag.
- Back-to-back push/pop at full rate is supported with no bubbles.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, then pop three times:
  - data_out reads 0x33, 0x22, 0x11 on consecutive cycles with rd_valid high for 3 cycles;
  - count ends at 0 and empty=1.
- Fill DEPTH=16 entries with values 0..15:
  - full=1 and top=15;
  - a 17th push of 0xFF sets overflow=1 and leaves top=15 and count=16;
  - err_clr then clears overflow.
- Pop when empty: underflow=1, rd_valid stays 0, data_out holds its previous value. Push+pop when empty with data_in=0xAB: count=1, top=0xAB, underflow=1.
- With the stack holding 0x5,0x6, assert push+pop with data_in=0x7: data_out=0x6, rd_valid=1, top=0x7, count=2. Repeat while full: no overflow.
- Fill to 10 entries, then assert flush together with write_en: count=0, empty=1, rd_valid=0, data_out unchanged. Assert err_clr in the same cycle as an overflowing push: overflow remains 1.
- Assert rst_n low asynchronously midway through a push/pop burst: all outputs reach their reset values before the next clk edge. After release, the stack is empty and accepts pushes normally.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with status, sticky errors, replace and flush.
// Ports: clk, rst_n, write_en/read_en/data_in/flush/err_clr in; data_out,
// rd_valid, top, count, empty, full, overflow, underflow out.
module lifo_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rdv;
  logic                  r_ovf;
  logic                  r_udf;

  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_push_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_act;
  logic          w_replace;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_udf_set;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_WIDTH'(DEPTH));
  assign w_top_idx  = AW'(r_count - CNT_WIDTH'(1));
  assign w_push_idx = AW'(r_count);

  // flush pre-empts any push or pop in the same cycle
  assign w_act     = ~flush;
  assign w_replace = w_act & write_en & read_en & ~w_empty;
  // push+pop on an empty stack still performs the push
  assign w_push    = w_act & write_en &
                     (read_en ? w_empty : ~w_full);
  assign w_pop     = w_act & read_en & ~write_en & ~w_empty;
  assign w_ovf_set = w_act & write_en & ~read_en & w_full;
  assign w_udf_set = w_act & read_en & w_empty;

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_push_idx] <= data_in;
    end else if (w_replace) begin
      r_mem[w_top_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_dout  <= '0;
      r_rdv   <= 1'b0;
    end else begin
      r_rdv <= w_replace | w_pop;
      if (flush) begin
        r_count <= '0;
      end else if (w_push) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_pop) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
      if (w_replace | w_pop) begin
        r_dout <= r_mem[w_top_idx];
      end
    end
  end

  // a new error in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (err_clr) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign top       = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign data_out  = r_dout;
  assign rd_valid  = r_rdv;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed table-driven bench for lifo_stack.
// Drives on negedge, checks #1 after posedge.
module tb_lifo_stack;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_in;
  logic        flush;
  logic        err_clr;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [31:0] top;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  lifo_stack #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .flush(flush), .err_clr(err_clr),
    .data_out(data_out), .rd_valid(rd_valid),
    .top(top), .count(count),
    .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic        fl;
    logic        ec;
    logic [31:0] din;
    logic [4:0]  c;
    logic [31:0] tp;
    logic [31:0] dout;
    logic        rdv;
    logic        ovf;
    logic        udf;
  } vec_t;

  int n_run;
  int n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input vec_t e);
    chk({nm, ".count"}, 32'(count), 32'(e.c));
    chk({nm, ".top"}, top, e.tp);
    chk({nm, ".dout"}, data_out, e.dout);
    chk({nm, ".rdv"}, 32'(rd_valid), 32'(e.rdv));
    chk({nm, ".ovf"}, 32'(overflow), 32'(e.ovf));
    chk({nm, ".udf"}, 32'(underflow), 32'(e.udf));
    chk({nm, ".empty"}, 32'(empty), 32'(e.c == 5'd0));
    chk({nm, ".full"}, 32'(full), 32'(e.c == 5'd16));
  endtask

  task automatic step(input vec_t e);
    @(negedge clk);
    write_en = e.we;
    read_en  = e.re;
    flush    = e.fl;
    err_clr  = e.ec;
    data_in  = e.din;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    data_in  = '0;
  endtask

  task automatic run(input string nm, input vec_t e);
    step(e);
    chk_all(nm, e);
  endtask

  vec_t tbl [15];
  vec_t e;

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    data_in  = '0;

    // we re fl ec din | count top dout rdv ovf udf
    tbl[0]  = '{1,0,0,0,32'h11, 5'd1, 32'h11, 32'h0,  0,0,0};
    tbl[1]  = '{1,0,0,0,32'h22, 5'd2, 32'h22, 32'h0,  0,0,0};
    tbl[2]  = '{1,0,0,0,32'h33, 5'd3, 32'h33, 32'h0,  0,0,0};
    tbl[3]  = '{0,1,0,0,32'h0,  5'd2, 32'h22, 32'h33, 1,0,0};
    tbl[4]  = '{0,1,0,0,32'h0,  5'd1, 32'h11, 32'h22, 1,0,0};
    tbl[5]  = '{0,1,0,0,32'h0,  5'd0, 32'h0,  32'h11, 1,0,0};
    tbl[6]  = '{0,1,0,0,32'h0,  5'd0, 32'h0,  32'h11, 0,0,1};
    tbl[7]  = '{1,1,0,0,32'hAB, 5'd1, 32'hAB, 32'h11, 0,0,1};
    tbl[8]  = '{0,0,0,1,32'h0,  5'd1, 32'hAB, 32'h11, 0,0,0};
    tbl[9]  = '{0,1,0,0,32'h0,  5'd0, 32'h0,  32'hAB, 1,0,0};
    tbl[10] = '{1,0,0,0,32'h5,  5'd1, 32'h5,  32'hAB, 0,0,0};
    tbl[11] = '{1,0,0,0,32'h6,  5'd2, 32'h6,  32'hAB, 0,0,0};
    tbl[12] = '{1,1,0,0,32'h7,  5'd2, 32'h7,  32'h6,  1,0,0};
    tbl[13] = '{0,1,0,0,32'h0,  5'd1, 32'h5,  32'h7,  1,0,0};
    tbl[14] = '{0,1,0,0,32'h0,  5'd0, 32'h0,  32'h5,  1,0,0};

    repeat (2) @(posedge clk);
    #1;
    e = '{0,0,0,0,32'h0, 5'd0, 32'h0, 32'h0, 0,0,0};
    chk_all("reset", e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run($sformatf("tbl%0d", i), tbl[i]);
    end

    for (int i = 0; i < 16; i++) begin
      e = '{1,0,0,0,32'(i), 5'(i+1), 32'(i), 32'h5, 0,0,0};
      run($sformatf("fill%0d", i), e);
    end

    e = '{1,0,0,0,32'hFF, 5'd16, 32'd15, 32'h5, 0,1,0};
    run("ovf_push", e);
    e = '{1,1,0,0,32'h99, 5'd16, 32'h99, 32'd15, 1,1,0};
    run("repl_full", e);
    e = '{0,0,0,1,32'h0,  5'd16, 32'h99, 32'd15, 0,0,0};
    run("clr_ovf", e);
    e = '{1,1,0,0,32'h9A, 5'd16, 32'h9A, 32'h99, 1,0,0};
    run("repl_full2", e);
    e = '{1,0,0,1,32'hFF, 5'd16, 32'h9A, 32'h99, 0,1,0};
    run("clr_vs_set", e);
    e = '{0,0,1,0,32'h0,  5'd0,  32'h0,  32'h99, 0,1,0};
    run("flush_full", e);
    e = '{0,0,0,1,32'h0,  5'd0,  32'h0,  32'h99, 0,0,0};
    run("clr2", e);

    for (int i = 0; i < 10; i++) begin
      e = '{1,0,0,0,32'h100+32'(i), 5'(i+1), 32'h100+32'(i),
            32'h99, 0,0,0};
      run($sformatf("fill10_%0d", i), e);
    end
    e = '{1,0,1,0,32'h77, 5'd0, 32'h0, 32'h99, 0,0,0};
    run("flush_we", e);
    e = '{0,1,1,0,32'h0,  5'd0, 32'h0, 32'h99, 0,0,0};
    run("flush_re_empty", e);

    for (int i = 0; i < 3; i++) begin
      e = '{1,0,0,0,32'h200+32'(i), 5'(i+1), 32'h200+32'(i),
            32'h99, 0,0,0};
      run($sformatf("burst%0d", i), e);
    end
    e = '{1,1,0,0,32'h55, 5'd3, 32'h55, 32'h202, 1,0,0};
    run("burst_repl", e);

    @(negedge clk);
    write_en = 1'b1;
    read_en  = 1'b1;
    data_in  = 32'h66;
    #2;
    rst_n = 1'b0;
    #1;
    e = '{0,0,0,0,32'h0, 5'd0, 32'h0, 32'h0, 0,0,0};
    chk_all("async_rst", e);
    @(posedge clk);
    #1;
    chk_all("rst_hold", e);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    rst_n    = 1'b1;

    e = '{1,0,0,0,32'h42, 5'd1, 32'h42, 32'h0,  0,0,0};
    run("post_push", e);
    e = '{0,1,0,0,32'h0,  5'd0, 32'h0,  32'h42, 1,0,0};
    run("post_pop", e);
    e = '{0,0,0,0,32'h0,  5'd0, 32'h0,  32'h42, 0,0,0};
    run("post_idle", e);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
